// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory read handshake, branch redirect, and the decode-side valid/stall pair.
// The master side is the fetch unit; the slave side is memory, execute and decode taken together.
interface pc_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, PC,
        input  imem_ack, imem_rdata, branch_taken, branch_target, stall
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, PC,
        output imem_ack, imem_rdata, branch_taken, branch_target, stall
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC sequencer and instruction fetcher: requests fetch_pc from memory, then holds the word for decode.
// A branch arriving while a request is outstanding is parked, and the in-flight data is dropped.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_1000,
    parameter logic [31:0] WORD_BYTES = 32'd4
) (
    input logic            clk,
    input logic            reset,
    pc_fetch_unit_if.master bus
);

    // state  | meaning
    // S_IDLE | first cycle out of reset
    // S_REQ  | imem_req high, waiting for imem_ack
    // S_HOLD | fetched word presented to decode until accepted
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    logic [31:0] target_al;

    assign target_al = {bus.branch_target[31:2], 2'b00};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            pc_q         <= RESET_PC;
            instr_q      <= 32'h0;
            valid_q      <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        valid_d      = valid_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (bus.branch_taken) begin
                    fetch_pc_d = target_al;
                end
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    redir_pend_d = 1'b0;
                    if (bus.branch_taken) begin
                        fetch_pc_d = target_al;
                    end else if (redir_pend_q) begin
                        fetch_pc_d = redir_tgt_q;
                    end else begin
                        instr_d    = bus.imem_rdata;
                        pc_d       = fetch_pc_q;
                        valid_d    = 1'b1;
                        fetch_pc_d = fetch_pc_q + WORD_BYTES;
                        state_d    = S_HOLD;
                    end
                end else if (bus.branch_taken) begin
                    // The request stays up; the redirect is applied when its ack returns.
                    redir_tgt_d  = target_al;
                    redir_pend_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (bus.branch_taken) begin
                    fetch_pc_d = target_al;
                    valid_d    = 1'b0;
                    state_d    = S_REQ;
                end else if (!bus.stall) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        bus.imem_req    = (state_q == S_REQ);
        bus.imem_addr   = fetch_pc_q;
        bus.instr       = instr_q;
        bus.instr_valid = valid_q;
        bus.PC          = pc_q;
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: directed scenarios followed by random stall/branch/ack-delay traffic.
// Expected PCs come from a queue fed by the stimulus; a negedge monitor pops and compares on each accept.
module tb_pc_fetch_unit;
    localparam logic [31:0] RST_PC  = 32'h0000_1000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk;
    logic reset;
    pc_fetch_unit_if bus();
    pc_fetch_unit_if w_if();

    pc_fetch_unit #(.RESET_PC(RST_PC), .WORD_BYTES(32'd4)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    pc_fetch_unit #(.RESET_PC(WRAP_PC), .WORD_BYTES(32'd4)) u_wrap (
        .clk(clk), .reset(reset), .bus(w_if));

    int checks = 0;
    int errors = 0;
    int nacc   = 0;
    int w_n    = 0;
    int cnt    = -1;
    int fixed_delay = 0;
    bit garbage_en  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_pc;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h t=%0t", nm, act, expv, $time);
        end
    endtask

    // One clock: memory answers for the coming edge, decode/execute inputs default to idle.
    task automatic step();
        @(posedge clk);
        #1;
        if (!bus.imem_req) begin
            cnt            = -1;
            bus.imem_ack   = garbage_en && ($urandom_range(0, 7) == 0);
            bus.imem_rdata = $urandom;
        end else begin
            if (cnt < 0) cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            if (cnt == 0) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = memf(bus.imem_addr);
                cnt            = -1;
            end else begin
                bus.imem_ack   = 1'b0;
                bus.imem_rdata = $urandom;
                cnt--;
            end
        end
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = $urandom;
        w_if.imem_ack     = w_if.imem_req;
        w_if.imem_rdata   = memf(w_if.imem_addr);
    endtask

    task automatic wait_req(input bit lvl, input string nm);
        int k;
        k = 0;
        while (bus.imem_req !== lvl && k < 50) begin
            step();
            k++;
        end
        chk(nm, 32'(k < 50), 32'd1);
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (bus.instr_valid !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        chk(nm, 32'(k < 50), 32'd1);
    endtask

    task automatic do_branch(input logic [31:0] tgt);
        bus.branch_taken  = 1'b1;
        bus.branch_target = tgt;
        exp_q.delete();
        exp_q.push_back({tgt[31:2], 2'b00});
    endtask

    // Monitor: model-based accept checks plus hold/freeze properties.
    initial begin
        logic        p_req, p_ack, p_valid, p_stall, p_br;
        logic [31:0] p_addr, p_pc, p_instr, e;
        p_req = 0; p_ack = 0; p_valid = 0; p_stall = 0; p_br = 0;
        p_addr = '0; p_pc = '0; p_instr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                p_req = 0; p_valid = 0; w_n = 0;
            end else begin
                if (p_req && !p_ack) begin
                    chk("req_held", 32'(bus.imem_req), 32'd1);
                    chk("addr_held", bus.imem_addr, p_addr);
                end
                if (p_valid && p_stall && !p_br) begin
                    chk("stall_valid", 32'(bus.instr_valid), 32'd1);
                    chk("stall_pc", bus.PC, p_pc);
                    chk("stall_instr", bus.instr, p_instr);
                    chk("stall_noreq", 32'(bus.imem_req), 32'd0);
                end
                if (bus.instr_valid && !bus.stall && !bus.branch_taken) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : last_pc + 32'd4;
                    chk("acc_pc", bus.PC, e);
                    chk("acc_instr", bus.instr, memf(e));
                    last_pc = e;
                    nacc++;
                end
                if (w_if.instr_valid && w_n < 4) begin
                    e = WRAP_PC + 32'(w_n) * 32'd4;
                    chk("wrap_pc", w_if.PC, e);
                    chk("wrap_instr", w_if.instr, memf(e));
                    w_n++;
                end
                p_req = bus.imem_req;  p_ack = bus.imem_ack;  p_addr = bus.imem_addr;
                p_valid = bus.instr_valid;  p_stall = bus.stall;  p_br = bus.branch_taken;
                p_pc = bus.PC;  p_instr = bus.instr;
            end
        end
    end

    initial begin
        int n;
        logic [31:0] spc;
        reset = 0;
        bus.imem_ack = 0; bus.imem_rdata = 0; bus.stall = 0;
        bus.branch_taken = 0; bus.branch_target = 0;
        w_if.imem_ack = 0; w_if.imem_rdata = 0; w_if.stall = 0;
        w_if.branch_taken = 0; w_if.branch_target = 0;
        exp_q = {RST_PC};
        last_pc = RST_PC;
        #12;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_pc", bus.PC, RST_PC);
        chk("rst_addr", bus.imem_addr, RST_PC);
        chk("rst_instr", bus.instr, 32'd0);
        @(negedge clk);
        reset = 1;

        // sequential fetch, immediate ack
        repeat (12) step();
        chk("t1_progress", 32'(nacc >= 3), 32'd1);

        // ack delayed three cycles
        fixed_delay = 3;
        wait_req(1'b0, "t2_wait_hold");
        wait_req(1'b1, "t2_wait_req");
        n = 1;
        while (!bus.imem_ack && n < 10) begin
            step();
            if (!bus.imem_ack) n++;
        end
        chk("t2_wait_cycles", 32'(n), 32'd3);

        // stall four cycles while valid
        fixed_delay = 0;
        wait_valid("t3_wait_valid");
        spc = {bus.PC[31:2], 2'b00};
        bus.stall = 1'b1;
        repeat (3) begin
            step();
            bus.stall = 1'b1;
        end
        chk("t3_pc_frozen", bus.PC, spc);
        step();

        // redirect in HOLD with unaligned target
        wait_valid("t4_wait_valid");
        do_branch(32'h0000_1013);
        step();
        chk("t4_req", 32'(bus.imem_req), 32'd1);
        chk("t4_addr", bus.imem_addr, 32'h0000_1010);

        // redirect while a request is outstanding
        fixed_delay = 2;
        wait_req(1'b0, "t5_wait_hold");
        wait_req(1'b1, "t5_wait_req");
        do_branch(32'h0000_2000);
        n = 0;
        do begin
            step();
            n++;
        end while (!(bus.imem_req && bus.imem_addr == 32'h0000_2000) && n < 12);
        chk("t5_redirect_seen", 32'(n < 12), 32'd1);
        chk("t5_dropped", 32'(bus.instr_valid), 32'd0);
        repeat (6) step();

        // reset mid-request
        fixed_delay = 5;
        wait_req(1'b0, "t7_wait_hold");
        wait_req(1'b1, "t7_wait_req");
        #2 reset = 0;
        #1;
        chk("t7_req_drop", 32'(bus.imem_req), 32'd0);
        chk("t7_addr", bus.imem_addr, RST_PC);
        exp_q = {RST_PC};
        repeat (2) @(posedge clk);
        #3 reset = 1;
        fixed_delay = 0;
        repeat (8) step();

        // random traffic
        fixed_delay = -1;
        garbage_en  = 1;
        repeat (400) begin
            step();
            if ($urandom_range(0, 2) == 0) bus.stall = 1'b1;
            if ($urandom_range(0, 15) == 0) begin
                spc = $urandom;
                if ($urandom_range(0, 1) == 0) spc = {16'h0000, spc[15:0]};
                do_branch(spc);
            end
        end
        garbage_en = 0;
        repeat (6) step();
        chk("progress", 32'(nacc >= 20), 32'd1);
        chk("wrap_progress", 32'(w_n >= 2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
